// File: rtl/step_pacer_pkg.sv
// Shared definitions for the step pacer: FSM state encoding.
package step_pacer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_WAIT = 3'd2,
        ST_PACE = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter that sets the WAIT length of the step pacer.
module step_timer
    import step_pacer_pkg::*;
#(
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [PER_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [PER_W-1:0] timer_q;
    logic [PER_W-1:0] timer_d;

    // Next timer value: load has priority, then count down and park at zero.
    always_comb begin
        timer_d = timer_q;
        if (load) begin
            timer_d = load_val;
        end else if (en && (timer_q != {PER_W{1'b0}})) begin
            timer_d = timer_q - {{(PER_W-1){1'b0}}, 1'b1};
        end else begin
            timer_d = timer_q;
        end
    end

    // Timer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= {PER_W{1'b0}};
        end else begin
            timer_q <= timer_d;
        end
    end

    assign zero = (timer_q == {PER_W{1'b0}});

endmodule

// File: rtl/step_pacer.sv
// Step-pulse generator: latches period/count on start, then emits paced step pulses.
module step_pacer
    import step_pacer_pkg::*;
#(
    parameter int PER_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [PER_W-1:0] period,
    input  logic [CNT_W-1:0] steps,
    output logic             step,
    output logic             timer_reload,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] step_cnt
);

    state_e           state_q, state_d;
    logic [PER_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             timer_zero_s;

    assign cnt_inc_s = step_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    step_timer #(
        .PER_W (PER_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state_q == ST_LOAD),
        .load_val (period_q),
        .en       (state_q == ST_WAIT),
        .zero     (timer_zero_s)
    );

    // Next-state logic: start overrides stop, stop overrides normal sequencing.
    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        steps_d    = steps_q;
        step_cnt_d = step_cnt_q;
        if (start) begin
            state_d    = ST_LOAD;
            period_d   = period;
            steps_d    = steps;
            step_cnt_d = {CNT_W{1'b0}};
        end else if (stop && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_LOAD: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (timer_zero_s) begin
                        state_d = ST_PACE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_PACE: begin
                    // steps_q == 0 runs forever; the counter simply wraps.
                    step_cnt_d = cnt_inc_s;
                    if ((steps_q != {CNT_W{1'b0}}) && (cnt_inc_s == steps_q)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, latch and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            period_q   <= {PER_W{1'b0}};
            steps_q    <= {CNT_W{1'b0}};
            step_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            steps_q    <= steps_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    assign step         = (state_q == ST_PACE);
    assign timer_reload = (state_q == ST_LOAD);
    assign busy         = (state_q == ST_LOAD) || (state_q == ST_WAIT) || (state_q == ST_PACE);
    assign done         = (state_q == ST_DONE);
    assign step_cnt     = step_cnt_q;

endmodule

// File: tb/tb_step_pacer.sv
// Directed self-checking bench for step_pacer (default widths plus a 4-bit counter instance).
module tb_step_pacer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [15:0] period;
    logic [15:0] steps;

    logic        step_a, reload_a, busy_a, done_a;
    logic [15:0] cnt_a;
    logic        step_b, reload_b, busy_b, done_b;
    logic [3:0]  cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    step_pacer #(.PER_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .period(period), .steps(steps),
        .step(step_a), .timer_reload(reload_a), .busy(busy_a),
        .done(done_a), .step_cnt(cnt_a)
    );

    step_pacer #(.PER_W(16), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .period(period), .steps(steps[3:0]),
        .step(step_b), .timer_reload(reload_b), .busy(busy_b),
        .done(done_b), .step_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge; afterwards we sit in cycle 1 (the LOAD cycle).
    task automatic go(input logic [15:0] per, input logic [15:0] stp);
        period = per;
        steps  = stp;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; period = 16'd0; steps = 16'd0;
        tick();
        n_checks++;
        if ({step_a, reload_a, busy_a, done_a, cnt_a} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b/%b/%b/%b cnt=%0d, want all 0",
                     step_a, reload_a, busy_a, done_a, cnt_a);
        end
        rst = 1'b0;
        tick(); tick();
        n_checks++;
        if (busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b, want 0", busy_a);
        end
    endtask

    task automatic test_counted();
        logic exp_step, exp_rl, exp_busy, exp_done;
        go(16'd4, 16'd3);
        for (int c = 1; c <= 26; c++) begin
            exp_step = (c == 7) || (c == 14) || (c == 21);
            exp_rl   = (c == 1) || (c == 8) || (c == 15);
            exp_busy = (c <= 21);
            exp_done = (c == 22);
            n_checks++;
            if ({step_a, reload_a, busy_a, done_a} !== {exp_step, exp_rl, exp_busy, exp_done}) begin
                n_fail++;
                $display("FAIL counted c=%0d: step/rl/busy/done=%b%b%b%b, want %b%b%b%b", c,
                         step_a, reload_a, busy_a, done_a, exp_step, exp_rl, exp_busy, exp_done);
            end
            tick();
        end
        n_checks++;
        if (cnt_a !== 16'd3) begin
            n_fail++;
            $display("FAIL counted_cnt: step_cnt=%0d, want 3", cnt_a);
        end
    endtask

    task automatic test_continuous_wrap();
        int k;
        go(16'd0, 16'd0);
        for (int c = 1; c <= 60; c++) begin
            k = c / 3;
            n_checks++;
            if (step_b !== ((c % 3) == 0) || step_a !== ((c % 3) == 0)) begin
                n_fail++;
                $display("FAIL wrap_step c=%0d: step=%b/%b, want %b", c, step_a, step_b, (c % 3) == 0);
            end
            if ((c % 3) == 0) begin
                n_checks++;
                if (cnt_b !== 4'((k - 1) % 16) || cnt_a !== 16'(k - 1)) begin
                    n_fail++;
                    $display("FAIL wrap_cnt c=%0d: cnt16=%0d cnt4=%0d, want %0d/%0d",
                             c, cnt_a, cnt_b, k - 1, (k - 1) % 16);
                end
            end
            n_checks++;
            if (done_a !== 1'b0 || done_b !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_done c=%0d: done=%b/%b, want 0", c, done_a, done_b);
            end
            tick();
        end
        halt();
    endtask

    task automatic test_stop();
        logic seen;
        go(16'd4, 16'd0);
        // Steps at cycles 7 and 14; cycle 17 is inside the next WAIT.
        for (int c = 1; c < 17; c++) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++;
        if (busy_a !== 1'b0 || cnt_a !== 16'd2) begin
            n_fail++;
            $display("FAIL stop_idle: busy=%b cnt=%0d, want 0/2", busy_a, cnt_a);
        end
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (step_a || done_a || busy_a) seen = 1'b1;
            tick();
        end
        n_checks++;
        if (seen !== 1'b0 || cnt_a !== 16'd2) begin
            n_fail++;
            $display("FAIL stop_quiet: activity=%b cnt=%0d, want 0/2", seen, cnt_a);
        end
    endtask

    task automatic test_restart();
        go(16'd10, 16'd0);
        // First step at cycle 13; cycle 16 is WAIT of the second interval.
        for (int c = 1; c < 16; c++) tick();
        go(16'd1, 16'd0);
        n_checks++;
        if (reload_a !== 1'b1 || cnt_a !== 16'd0) begin
            n_fail++;
            $display("FAIL restart_load: reload=%b cnt=%0d, want 1/0", reload_a, cnt_a);
        end
        for (int r = 1; r <= 12; r++) begin
            n_checks++;
            if (step_a !== ((r % 4) == 0)) begin
                n_fail++;
                $display("FAIL restart_interval r=%0d: step=%b, want %b", r, step_a, (r % 4) == 0);
            end
            tick();
        end
        halt();
    endtask

    task automatic test_priority();
        go(16'd4, 16'd0);
        tick(); tick();
        period = 16'd2;
        start  = 1'b1;
        stop   = 1'b1;
        tick();
        start  = 1'b0;
        stop   = 1'b0;
        period = 16'd9;
        n_checks++;
        if (reload_a !== 1'b1 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL priority_load: reload=%b busy=%b, want 1/1", reload_a, busy_a);
        end
        for (int r = 1; r <= 16; r++) begin
            n_checks++;
            if (step_a !== ((r % 5) == 0)) begin
                n_fail++;
                $display("FAIL priority_interval r=%0d: step=%b, want %b", r, step_a, (r % 5) == 0);
            end
            tick();
        end
        halt();
    endtask

    task automatic test_start_in_pace();
        go(16'd0, 16'd0);
        tick(); tick();
        start = 1'b1;
        #1;
        n_checks++;
        if (step_a !== 1'b1) begin
            n_fail++;
            $display("FAIL pace_start_step: step=%b, want 1", step_a);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++;
        if (reload_a !== 1'b1 || cnt_a !== 16'd0) begin
            n_fail++;
            $display("FAIL pace_start_cnt: reload=%b cnt=%0d, want 1/0", reload_a, cnt_a);
        end
        halt();
    endtask

    task automatic test_async_reset();
        go(16'd6, 16'd0);
        for (int c = 1; c < 12; c++) tick();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({step_a, reload_a, busy_a, done_a, cnt_a} !== 20'd0) begin
            n_fail++;
            $display("FAIL async_reset: step/rl/busy/done=%b%b%b%b cnt=%0d, want all 0",
                     step_a, reload_a, busy_a, done_a, cnt_a);
        end
        tick();
        #2;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++;
            if (busy_a !== 1'b0 || step_a !== 1'b0) begin
                n_fail++;
                $display("FAIL async_idle c=%0d: busy=%b step=%b, want 0/0", c, busy_a, step_a);
            end
        end
        go(16'd0, 16'd1);
        n_checks++;
        if (reload_a !== 1'b1) begin
            n_fail++;
            $display("FAIL async_restart: reload=%b, want 1", reload_a);
        end
        tick(); tick(); tick();
        n_checks++;
        if (done_a !== 1'b1 || cnt_a !== 16'd1) begin
            n_fail++;
            $display("FAIL single_done: done=%b cnt=%0d, want 1/1", done_a, cnt_a);
        end
    endtask

    initial begin
        test_reset();
        test_counted();
        test_continuous_wrap();
        test_stop();
        test_restart();
        test_priority();
        test_start_in_pace();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
